// File: rtl/druaga_vid_pkg.sv
// druaga_vid_pkg: default raster timing and colour expansion helpers for the Druaga video path.
package druaga_vid_pkg;
  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_H_ACTIVE = 288;
  localparam int DEF_HS_START = 304;
  localparam int DEF_HS_WIDTH = 32;
  localparam int DEF_V_TOTAL  = 264;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_WIDTH = 3;
  localparam int DEF_PIPE_DLY = 2;

  function automatic logic [7:0] expand3to8(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2to8(input logic [1:0] c);
    return {4{c}};
  endfunction
endpackage

// File: rtl/druaga_vid_delay.sv
// druaga_vid_delay: W-bit, D-stage shift register with clock enable and async reset load value.
module druaga_vid_delay #(
  parameter int W = 4,
  parameter int D = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         MCLK,
  input  logic         RESET,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [D-1:0][W-1:0] sr;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sr <= {D{INIT}};
    end else if (ce) begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];
endmodule

// File: rtl/druaga_vid_timing.sv
// druaga_vid_timing: pixel enable, raster counters and registered RGB/sync/blank output stage.
// Optional screen flip of PH/PV is built when DRUAGA_FLIP_EN is defined.
module druaga_vid_timing
  import druaga_vid_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_WIDTH = DEF_HS_WIDTH,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_WIDTH = DEF_VS_WIDTH,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       FLIP,
  input  logic [7:0] POUT,
  output logic       CE_PIX,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       HBLANK,
  output logic       VBLANK
);
  localparam logic [8:0] HT1 = 9'(H_TOTAL - 1);
  localparam logic [8:0] HA  = 9'(H_ACTIVE);
  localparam logic [8:0] HSS = 9'(HS_START);
  localparam logic [8:0] HSE = 9'(HS_START + HS_WIDTH);
  localparam logic [8:0] VT1 = 9'(V_TOTAL - 1);
  localparam logic [8:0] VA  = 9'(V_ACTIVE);
  localparam logic [8:0] VSS = 9'(VS_START);
  localparam logic [8:0] VSE = 9'(VS_START + VS_WIDTH);

  logic [2:0] div;
  logic [8:0] hcnt, vcnt, h_next, v_next, ph_next, pv_next;
  logic       h_wrap, v_wrap, hb, vb, hs, vs, blank;
  logic [3:0] dly;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      div    <= '0;
      CE_PIX <= 1'b0;
    end else begin
      div    <= div + 3'd1;
      CE_PIX <= div == 3'd7;
    end
  end

  always_comb begin
    h_wrap = hcnt == HT1;
    v_wrap = vcnt == VT1;
    h_next = h_wrap ? '0 : hcnt + 9'd1;
    v_next = h_wrap ? (v_wrap ? '0 : vcnt + 9'd1) : vcnt;
    hb     = hcnt >= HA;
    vb     = vcnt >= VA;
    hs     = hcnt >= HSS && hcnt < HSE;
    vs     = vcnt >= VSS && vcnt < VSE;
  end

`ifdef DRUAGA_FLIP_EN
  logic flip_q, flip_n;
  // Flip is only sampled on the frame wrap so a frame is never rendered half-flipped.
  assign flip_n  = (h_wrap && v_wrap) ? FLIP : flip_q;
  assign ph_next = (flip_n && h_next < HA) ? HA - 9'd1 - h_next : h_next;
  assign pv_next = (flip_n && v_next < VA) ? VA - 9'd1 - v_next : v_next;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) flip_q <= 1'b0;
    else if (CE_PIX) flip_q <= flip_n;
  end
`else
  logic unused_flip;
  assign unused_flip = FLIP;
  assign ph_next     = h_next;
  assign pv_next     = v_next;
`endif

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      hcnt <= '0;
      vcnt <= '0;
      PH   <= '0;
      PV   <= '0;
    end else if (CE_PIX) begin
      hcnt <= h_next;
      vcnt <= v_next;
      PH   <= ph_next;
      PV   <= pv_next;
    end
  end

  druaga_vid_delay #(.W(4), .D(PIPE_DLY), .INIT(4'b1100)) u_dly (
    .MCLK  (MCLK),
    .RESET (RESET),
    .ce    (CE_PIX),
    .d     ({hb, vb, hs, vs}),
    .q     (dly)
  );

  assign blank = dly[3] | dly[2];

  // Final register aligns sync/blank with the colour sampled from POUT on the same edge.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      R <= '0;
      G <= '0;
      B <= '0;
      {HBLANK, VBLANK, HSYNC, VSYNC} <= 4'b1100;
    end else if (CE_PIX) begin
      R <= blank ? '0 : expand3to8(POUT[7:5]);
      G <= blank ? '0 : expand3to8(POUT[4:2]);
      B <= blank ? '0 : expand2to8(POUT[1:0]);
      {HBLANK, VBLANK, HSYNC, VSYNC} <= dly;
    end
  end
endmodule

// File: tb/tb_druaga_vid_timing.sv
// tb_druaga_vid_timing: scoreboard bench for the video timing block on a reduced raster.
module tb_druaga_vid_timing;
  localparam int HT = 48, HA = 36, HSS = 38, HSW = 4;
  localparam int VT = 12, VA = 8, VSS = 9, VSW = 2, PD = 2;
  localparam int N_PIX = 1300;

  typedef struct {
    logic [23:0] rgb;
    logic [3:0]  ctl;
  } exp_t;

  logic       MCLK = 1'b0, RESET = 1'b1, FLIP = 1'b0;
  logic [7:0] POUT = '0;
  logic       CE_PIX, HSYNC, VSYNC, HBLANK, VBLANK;
  logic [8:0] PH, PV;
  logic [7:0] R, G, B;

  int n_checks = 0, n_errors = 0;
  exp_t q[$];
  logic [17:0] cq[$];

  always #5 MCLK = ~MCLK;

  druaga_vid_timing #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_WIDTH(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_WIDTH(VSW), .PIPE_DLY(PD)
  ) dut (
    .MCLK(MCLK), .RESET(RESET), .FLIP(FLIP), .POUT(POUT), .CE_PIX(CE_PIX),
    .PH(PH), .PV(PV), .R(R), .G(G), .B(B),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK(HBLANK), .VBLANK(VBLANK)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_coord"}, {14'd0, PV, PH}, 32'd0);
    check({tag, "_ce"}, {31'd0, CE_PIX}, 32'd0);
    check({tag, "_rgb"}, {8'd0, R, G, B}, 32'd0);
    check({tag, "_ctl"}, {28'd0, HBLANK, VBLANK, HSYNC, VSYNC}, 32'hC);
  endtask

  function automatic logic [3:0] dec(input logic [17:0] c);
    int h, v;
    h = int'(c[8:0]);
    v = int'(c[17:9]);
    return {h >= HA, v >= VA, h >= HSS && h < HSS + HSW, v >= VSS && v < VSS + VSW};
  endfunction

  function automatic logic [23:0] col(input logic [7:0] p, input logic blank);
    int r, g, b;
    r = (int'(p[7:5]) * 255 + 3) / 7;
    g = (int'(p[4:2]) * 255 + 3) / 7;
    b = int'(p[1:0]) * 85;
    return blank ? 24'd0 : {8'(r), 8'(g), 8'(b)};
  endfunction

  initial begin
    int first = 0, second = 0, mh = 0, mv = 0, w;
    exp_t e, got;
    logic [17:0] c;
    repeat (3) @(posedge MCLK);
    #1 check_rst("rst");
    @(negedge MCLK);
    RESET = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge MCLK);
      #1;
      if (CE_PIX && first == 0) first = i;
      else if (CE_PIX && second == 0) second = i;
    end
    check("first_ce_edge", first, 8);
    check("second_ce_edge", second, 16);
    repeat (100) @(posedge MCLK);
    #2 RESET = 1'b1;
    #1 check_rst("midline_rst");
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b0;
    cq.push_back('0);
    for (int m = 1; m <= N_PIX; m++) begin
      w = 0;
      while (!CE_PIX && w < 16) begin
        @(negedge MCLK);
        w++;
      end
      if (!CE_PIX) begin
        check("ce_timeout", 0, 1);
        break;
      end
      POUT = (m % 4 == 0) ? 8'hFF : (m % 4 == 1) ? 8'hA6 : (m % 4 == 2) ? 8'h00 : 8'($urandom);
      FLIP = 1'($urandom_range(0, 1));
      if (m <= PD) begin
        e.rgb = '0;
        e.ctl = 4'b1100;
      end else begin
        c = cq.pop_front();
        e.ctl = dec(c);
        e.rgb = col(POUT, e.ctl[3] | e.ctl[2]);
      end
      q.push_back(e);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      cq.push_back({9'(mv), 9'(mh)});
      @(negedge MCLK);
      got = q.pop_front();
      check("coord", {14'd0, PV, PH}, {14'd0, 9'(mv), 9'(mh)});
      check("rgb", {8'd0, R, G, B}, {8'd0, got.rgb});
      check("ctl", {28'd0, HBLANK, VBLANK, HSYNC, VSYNC}, {28'd0, got.ctl});
    end
    check("sb_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/druaga_vid_timing.md
# druaga_vid_timing

Video timing generator and pixel output stage for the Druaga core. It produces the 6.14 MHz pixel enable and the `PH`/`PV` raster coordinates that drive the video core. It takes the core's 8-bit `POUT` colour back, delays blank and sync to match that pixel, and drives registered 24-bit RGB with syncs and blanks to the platform video path.

## Interface
Parameters:
- `H_TOTAL`, 384: pixels per line.
- `H_ACTIVE`, 288: visible pixels per line.
- `HS_START`, 304: first pixel (raw `hcnt`) with HSYNC asserted.
- `HS_WIDTH`, 32: HSYNC width in pixels.
- `V_TOTAL`, 264: lines per frame.
- `V_ACTIVE`, 224: visible lines per frame.
- `VS_START`, 240: first line with VSYNC asserted.
- `VS_WIDTH`, 3: VSYNC width in lines.
- `PIPE_DLY`, 2: pixel latency from `PH`/`PV` to valid `POUT`. Range 1..7.

Ports:
- `MCLK` in 1: master clock, 49.125 MHz.
- `RESET` in 1: reset. Asynchronous, active-high.
- `FLIP` in 1: screen-flip request. Used only when `DRUAGA_FLIP_EN` is defined.
- `POUT` in 8: pixel colour from the video core, RRRGGGBB.
- `CE_PIX` out 1: pixel enable, one `MCLK` wide.
- `PH` out 9: horizontal coordinate to the video core.
- `PV` out 9: vertical coordinate to the video core.
- `R`, `G`, `B` out 8 each: expanded colour.
- `HSYNC`, `VSYNC` out 1 each: active-high syncs.
- `HBLANK`, `VBLANK` out 1 each: active-high blanks.

## Operation
- Prescaler:
  - 3-bit `div` increments every `MCLK`.
  - `CE_PIX` is registered high for the cycle after `div==7`, so it is high exactly 1 cycle in 8.
- Counters (advance only on `CE_PIX`):
  - `hcnt` counts 0..`H_TOTAL`-1, then wraps to 0.
  - On each `hcnt` wrap, `vcnt` advances 0..`V_TOTAL`-1, then wraps to 0.
- Coordinates:
  - `PH` = `hcnt`, `PV` = `vcnt`. Both are registered and update on the same edge as the counters.
- Raw timing signals, decoded from the counters:
  - `hb` = `hcnt` >= `H_ACTIVE`.
  - `vb` = `vcnt` >= `V_ACTIVE`.
  - `hs` = `HS_START` <= `hcnt` < `HS_START`+`HS_WIDTH`.
  - `vs` = `VS_START` <= `vcnt` < `VS_START`+`VS_WIDTH`.
- Delay line:
  - {`hb`,`vb`,`hs`,`vs`} pass through a `PIPE_DLY`-stage shift register that advances on `CE_PIX`.
  - The outputs `HBLANK`/`VBLANK`/`HSYNC`/`VSYNC` are the last stage.
- Colour (registered on `CE_PIX`):
  - If delayed `hb|vb`: `R`=`G`=`B`=0.
  - Otherwise, with r=`POUT`[7:5], g=`POUT`[4:2], b=`POUT`[1:0]:
    - `R` = {r,r,r[2:1]}
    - `G` = {g,g,g[2:1]}
    - `B` = {b,b,b,b}
- Boundary behaviour:
  - The `hcnt` wrap and the `vcnt` wrap on the same `CE_PIX` both take effect on that edge.
  - `RESET` asserted mid-line clears all state immediately. Counting restarts at pixel (0,0) on the first `MCLK` edge after release.

## Timing
- Reset values:
  - `div`, `hcnt`, `vcnt` = 0.
  - `PH`, `PV` = 0.
  - `CE_PIX` = 0.
  - `R`, `G`, `B` = 0.
  - `HSYNC`, `VSYNC` = 0.
  - `HBLANK`, `VBLANK` = 1.
  - All delay stages are loaded with blank=1 and sync=0.
- After `RESET` releases, the first `CE_PIX` is on the 8th `MCLK` edge.
- Line period = 3072 `MCLK`. Frame period = 811008 `MCLK`.
- Latency from `PH`/`PV` change to the matching `RGB`/sync/blank output = `PIPE_DLY`+1 `CE_PIX` periods.
- `POUT` is sampled only on `CE_PIX` cycles.

## Configuration
- `DRUAGA_FLIP_EN` defined:
  - `FLIP` is latched into `flip_q` only on the `CE_PIX` where `vcnt` wraps to 0, so the flip never changes mid-frame. `flip_q` resets to 0.
  - While `flip_q`=1:
    - `PH` = `H_ACTIVE`-1-`hcnt` for `hcnt`<`H_ACTIVE`, else `hcnt`.
    - `PV` = `V_ACTIVE`-1-`vcnt` for `vcnt`<`V_ACTIVE`, else `vcnt`.
  - Syncs and blanks are unaffected by the flip.
- `DRUAGA_FLIP_EN` not defined: `FLIP` is ignored, no flip register exists, and `PH`/`PV` are always the raw counters.

## Structure
- Package `druaga_vid_pkg` holds:
  - the default timing constants (384/288/304/32/264/224/240/3);
  - a function `expand3to8`;
  - a function `expand2to8`.
- Sub-module `druaga_vid_delay`: parameterised width × depth shift register with clock enable and asynchronous reset load value. It is used for the sync/blank pipeline.

## Test plan
- Reset and clock enable: assert `RESET` mid-line → all outputs hold their reset values immediately; after release, `CE_PIX` first pulses on `MCLK` edge 8 and then every 8 edges.
- Line and frame length:
  - `PH` sequence is 0..383 then 0.
  - `PV` increments once per 3072 `MCLK`.
  - `PV` wraps from 263 to 0, with both counters wrapping on the same edge.
- Sync and blank placement with `PIPE_DLY`=2:
  - `HSYNC` rises 3 `CE_PIX` after `PH`=304 and lasts 32 pixels.
  - `HBLANK` rises 3 `CE_PIX` after `PH`=288.
  - `VSYNC` covers lines 240..242, delayed by the same amount.
- Colour expansion:
  - `POUT`=8'hFF → FF/FF/FF.
  - `POUT`=8'b101_001_10 → `R`=B6, `G`=24, `B`=AA.
  - Any `POUT` during a delayed blank → 00/00/00.
- Flip (`DRUAGA_FLIP_EN`):
  - Raise `FLIP` at `vcnt`=100 → `PH`/`PV` stay raw until the next frame.
  - In that next frame, at `hcnt`=0, `vcnt`=0 the outputs are `PH`=287, `PV`=223.
  - At `hcnt`=300 the output is `PH`=300.
- Flip disabled: build without `DRUAGA_FLIP_EN` and toggle `FLIP` → no change on any output.
